// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and write constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      LEN_LO = 3'd0,
      LEN_HI = 3'd1,
      DATA   = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_t;

   localparam int         WORD_BYTES = 4;
   localparam logic [3:0] WE_ALL     = 4'hF;

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle watchdog: counts consecutive enabled cycles without a clear and flags
// expiry on the TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES = 0 disables it.
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned   CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // cnt_q holds the number of idle cycles already completed before this one.
   assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image from a byte source into BRAM port A and releases
// the core reset when done. Define LOADER_CHECKSUM_EN to require a trailing mod-256 check byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 4096,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        start,
   output logic [3:0]  wea,
   output logic [31:0] addra,
   output logic [31:0] dia,
   output logic        core_rst_n,
   output logic        load_done,
   output logic        load_error,
   output logic [15:0] words_loaded,
   output state_t      dbg_state_o
);

   localparam int           BCW     = $clog2(WORD_BYTES);
   localparam int           BUFW    = 8 * (WORD_BYTES - 1);
   localparam logic [BCW-1:0] BC_LAST = BCW'(WORD_BYTES - 1);
`ifdef LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CHECK;
`else
   localparam state_t AFTER_DATA = DONE;
`endif

   state_t          state_q, state_d;
   logic [7:0]      len_lo_q, len_lo_d;
   logic [15:0]     len_q, len_d;
   logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
   logic [BUFW-1:0] buf_q, buf_d;
   logic [3:0]      wea_q, wea_d;
   logic [31:0]     addra_q, addra_d;
   logic [31:0]     dia_q, dia_d;
   logic [15:0]     words_q, words_d;
   logic            core_rst_n_q, core_rst_n_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]      sum_q, sum_d;
`endif
   logic            accept;
   logic            expired;

   assign rx_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == CHECK);
   assign accept   = rx_valid && rx_ready;

   loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (accept),
      .en_i      ((state_q == LEN_HI) || (state_q == DATA) || (state_q == CHECK)),
      .expired_o (expired)
   );

   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      buf_d      = buf_q;
      wea_d      = '0;
      addra_d    = addra_q;
      dia_d      = dia_q;
      words_d    = words_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      case (state_q)
         LEN_LO: begin
            if (accept) begin
               len_lo_d = rx_data;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d      = {rx_data, len_lo_q};
               byte_cnt_d = '0;
               if ({16'd0, len_d} > MAX_WORDS) state_d = ERR;
               else if (len_d == 16'd0)        state_d = AFTER_DATA;
               else                            state_d = DATA;
            end else if (expired) begin
               state_d = ERR;
            end
         end
         DATA: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
               sum_d = sum_q + rx_data;
`endif
               if (byte_cnt_q == BC_LAST) begin
                  // Final byte of a word: issue the write next cycle; bytes keep flowing.
                  wea_d      = WE_ALL;
                  addra_d    = BASE_ADDR + {14'd0, words_q, 2'b00};
                  dia_d      = {rx_data, buf_q};
                  words_d    = words_q + 16'd1;
                  byte_cnt_d = '0;
                  if (words_d == len_q) state_d = AFTER_DATA;
               end else begin
                  buf_d      = {rx_data, buf_q[BUFW-1:8]};
                  byte_cnt_d = byte_cnt_q + BCW'(1);
               end
            end else if (expired) begin
               state_d = ERR;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept)       state_d = (rx_data == sum_q) ? DONE : ERR;
            else if (expired) state_d = ERR;
         end
`endif
         DONE, ERR: begin
            if (start) begin
               state_d = LEN_LO;
               words_d = '0;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         default: state_d = ERR;
      endcase
      // Core leaves reset one cycle after DONE is entered, so the last write has landed.
      core_rst_n_d = (state_q == DONE) && (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LEN_LO;
         len_lo_q     <= '0;
         len_q        <= '0;
         byte_cnt_q   <= '0;
         buf_q        <= '0;
         wea_q        <= '0;
         addra_q      <= BASE_ADDR;
         dia_q        <= '0;
         words_q      <= '0;
         core_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         byte_cnt_q   <= byte_cnt_d;
         buf_q        <= buf_d;
         wea_q        <= wea_d;
         addra_q      <= addra_d;
         dia_q        <= dia_d;
         words_q      <= words_d;
         core_rst_n_q <= core_rst_n_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign wea          = wea_q;
   assign addra        = addra_q;
   assign dia          = dia_q;
   assign words_loaded = words_q;
   assign core_rst_n   = core_rst_n_q;
   assign load_done    = (state_q == DONE);
   assign load_error   = (state_q == ERR);
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames, length/timeout errors, restart, mid-frame reset and
// random images against a byte-level reference model. Honours +define+LOADER_CHECKSUM_EN.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int unsigned MAXW = 4096;
   localparam int unsigned TMO  = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        start = 1'b0;
   logic [3:0]  wea;
   logic [31:0] addra, dia;
   logic        core_rst_n, load_done, load_error;
   logic [15:0] words_loaded;
   logic [2:0]  dbg_state;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          bad_we = 0;
   logic [63:0] got_q[$];
   logic [63:0] exp_q[$];
   logic [31:0] frame_w[$];

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .start        (start),
      .wea          (wea),
      .addra        (addra),
      .dia          (dia),
      .core_rst_n   (core_rst_n),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded),
      .dbg_state_o  (dbg_state)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Write monitor: every BRAM write cycle as {address, data}
   always @(negedge clk) begin
      if (wea === 4'hF)       got_q.push_back({addra, dia});
      else if (wea !== 4'h0)  bad_we++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Presents one byte at a negedge; it must be taken on the following posedge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      chk("rx_ready_at_send", rx_ready, 1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_wea"},        wea, 0);
      chk({tag, "_addra"},      addra, BASE);
      chk({tag, "_dia"},        dia, 0);
      chk({tag, "_core_rst_n"}, core_rst_n, 0);
      chk({tag, "_load_done"},  load_done, 0);
      chk({tag, "_load_error"}, load_error, 0);
      chk({tag, "_words"},      words_loaded, 0);
      chk({tag, "_rx_ready"},   rx_ready, 1);
   endtask

   // Scoreboard: observed writes against the model's expected writes
   task automatic check_writes(input string tag);
      chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0)
         chk({tag, "_write"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
      chk({tag, "_bad_we"}, 64'(bad_we), 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_load_error", load_error, 0);
      chk("start_load_done",  load_done, 0);
      chk("start_core_rst_n", core_rst_n, 0);
      chk("start_words",      words_loaded, 0);
      chk("start_rx_ready",   rx_ready, 1);
   endtask

   // Reference model: builds the byte stream and expected writes from frame_w, then drives it.
   task automatic run_frame(input int max_gap, input bit bad_sum);
      logic [7:0] bytes[$];
      logic [7:0] sum;
      logic [7:0] b;
      int         len;
      int         w;
      sum = 8'h00;
      len = frame_w.size();
      bytes.push_back(len[7:0]);
      bytes.push_back(len[15:8]);
      foreach (frame_w[k]) begin
         for (int j = 0; j < 4; j++) begin
            b = frame_w[k][8*j +: 8];
            bytes.push_back(b);
            sum = sum + b;
         end
         exp_q.push_back({BASE + 32'(4 * k), frame_w[k]});
      end
`ifdef LOADER_CHECKSUM_EN
      bytes.push_back(bad_sum ? sum + 8'h01 : sum);
`endif
      foreach (bytes[i]) begin
         if (i > 0 && max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
         send_byte(bytes[i]);
      end
      w = 0;
      while (load_done !== 1'b1 && load_error !== 1'b1 && w < 8) begin
         @(negedge clk);
         w++;
      end
      if (bad_sum) begin
         chk("sum_load_error", load_error, 1);
         chk("sum_load_done",  load_done, 0);
      end else begin
         chk("load_done",            load_done, 1);
         chk("core_rst_n_first_cyc", core_rst_n, 0);
      end
      @(negedge clk);
      chk("core_rst_n_after", core_rst_n, bad_sum ? 0 : 1);
      chk("words_loaded",     words_loaded, 64'(len));
      chk("rx_ready_final",   rx_ready, 0);
      check_writes("frame");
   endtask

   initial begin
      // Reset
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      // Two-word image at one byte per cycle
      frame_w = '{32'h0000_0013, 32'h0000_006F};
      run_frame(0, 1'b0);

      // Length over MAX_WORDS
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h10);
      chk("len_err_load_error", load_error, 1);
      chk("len_err_rx_ready",   rx_ready, 0);
      chk("len_err_core_rst_n", core_rst_n, 0);
      @(negedge clk);
      chk("len_err_load_done", load_done, 0);
      check_writes("len_err");

      // Restart from ERR with an empty image
      pulse_start();
      frame_w.delete();
      run_frame(0, 1'b0);

      // Idle timeout inside a word
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      idle(int'(TMO) - 1);
      chk("tmo_before", load_error, 0);
      @(negedge clk);
      chk("tmo_at",            load_error, 1);
      chk("tmo_core_rst_n",    core_rst_n, 0);
      chk("tmo_words",         words_loaded, 0);
      @(negedge clk);
      check_writes("tmo");

      // Largest legal count is accepted, then the stalled frame times out
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h10);
      chk("maxw_no_error", load_error, 0);
      chk("maxw_rx_ready", rx_ready, 1);
      idle(int'(TMO));
      chk("maxw_tmo_error", load_error, 1);

      // Reset mid-frame, then a fresh frame
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hEF);
      send_byte(8'hBE);
      rst = 1'b1;
      #1;
      check_reset_vals("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_writes("mid_rst");
      frame_w = '{32'hDEAD_BEEF};
      run_frame(0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      // Check byte match and mismatch
      pulse_start();
      frame_w = '{32'h0403_0201};
      run_frame(0, 1'b0);
      pulse_start();
      run_frame(0, 1'b1);
`endif

      // Random images with random inter-byte gaps
      for (int f = 0; f < 8; f++) begin
         int n;
         pulse_start();
         frame_w.delete();
         n = (f == 7) ? int'($urandom_range(40, 20)) : int'($urandom_range(6, 1));
         for (int i = 0; i < n; i++) frame_w.push_back($urandom());
         run_frame(3, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
